sensor_debounce: RTL and testbench

SENSOR_DEBOUNCE -- requirements
Module: sensor_debounce

---
 rtl/sensor_debounce_if.sv | 25 ++
 rtl/sensor_debounce.sv | 183 ++++++++++++++++++
 tb/tb_sensor_debounce.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sensor_debounce_if.sv
// Sensor bundle between the raw contact inputs and the robot controller.
// The debouncer takes the slave view: it reads the raw_* contacts and drives
// the debounced levels, the changed strobe and the fault flag.
interface sensor_debounce_if;
  logic raw_head;
  logic raw_left;
  logic raw_under;
  logic raw_barrier;
  logic head;
  logic left;
  logic under;
  logic barrier;
  logic changed;
  logic fault;

  modport master (
    output raw_head, raw_left, raw_under, raw_barrier,
    input  head, left, under, barrier, changed, fault
  );

  modport slave (
    input  raw_head, raw_left, raw_under, raw_barrier,
    output head, left, under, barrier, changed, fault
  );
endinterface

// File: rtl/sensor_debounce.sv
// Four-channel contact debouncer for the robot's head/left/under/barrier
// sensors. Each raw contact is synchronized by two flops, then a per-channel
// STABLE/CHECK FSM accepts a new level only after DEBOUNCE_CYCLES consecutive
// samples that disagree with the current output. 'changed' pulses for one
// cycle whenever any output updates.
// Optional feature: define SENSOR_FAULT_EN to add per-channel saturating
// glitch counters and a sticky 'fault' flag raised when any channel rejects
// GLITCH_LIMIT glitches. Without it 'fault' is tied low.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GLITCH_LIMIT    = 8
) (
  input  logic               clock,
  input  logic               reset,
  sensor_debounce_if.slave   bus
);

  localparam int         NCH        = 4;
  localparam logic [3:0] CNT_LAST   = 4'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } state_t;

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 15 ||
      GLITCH_LIMIT < 1 || GLITCH_LIMIT > 15) begin : g_param_check
    $error("sensor_debounce: DEBOUNCE_CYCLES must be 2..15, GLITCH_LIMIT 1..15");
  end

  // Channel order in all vectors: 0 head, 1 left, 2 under, 3 barrier.
  logic [NCH-1:0] raw;
  logic [NCH-1:0] sync_p0;
  logic [NCH-1:0] sync_p1;
  logic [NCH-1:0] lvl;
  logic [NCH-1:0] upd;
  logic           changed_q;

  assign raw = {bus.raw_barrier, bus.raw_under, bus.raw_left, bus.raw_head};

`ifdef SENSOR_FAULT_EN
  localparam logic [3:0] GLITCH_LIM = 4'(GLITCH_LIMIT);

  logic [NCH-1:0] hit;
  logic           fault_q;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction
`endif

  // Two-flop synchronizer on every raw contact before any other use.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    state_t     state_q;
    state_t     state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       out_q;
    logic       out_d;
    logic       upd_c;
`ifdef SENSOR_FAULT_EN
    logic       glitch_c;
    logic [3:0] gcnt_q;
    logic [3:0] gcnt_d;
`endif

    // Channel state, run counter and debounced level.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state_q <= STABLE;
        cnt_q   <= '0;
        out_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        out_q   <= out_d;
      end
    end

    // Next state: count disagreeing samples, accept on the last one,
    // and treat an early return to the current level as a glitch.
    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      out_d    = out_q;
      upd_c    = 1'b0;
`ifdef SENSOR_FAULT_EN
      glitch_c = 1'b0;
`endif
      case (state_q)
        STABLE: begin
          if (sync_p1[ch] != out_q) begin
            state_d = CHECK;
            cnt_d   = 4'd1;
          end else begin
            cnt_d   = 4'd0;
          end
        end
        CHECK: begin
          if (sync_p1[ch] == out_q) begin
            state_d  = STABLE;
            cnt_d    = 4'd0;
`ifdef SENSOR_FAULT_EN
            glitch_c = 1'b1;
`endif
          end else if (cnt_q >= CNT_LAST) begin
            // Comparing with >= keeps the counter from ever running past
            // the acceptance point.
            out_d   = sync_p1[ch];
            state_d = STABLE;
            cnt_d   = 4'd0;
            upd_c   = 1'b1;
          end else begin
            cnt_d   = cnt_q + 4'd1;
          end
        end
        default: begin
          state_d = STABLE;
          cnt_d   = 4'd0;
        end
      endcase
    end

    assign lvl[ch] = out_q;
    assign upd[ch] = upd_c;

`ifdef SENSOR_FAULT_EN
    assign gcnt_d  = glitch_c ? sat_inc(gcnt_q) : gcnt_q;
    // 'hit' fires only on the edge where the count first arrives at the limit.
    assign hit[ch] = (gcnt_q != GLITCH_LIM) && (gcnt_d == GLITCH_LIM);

    // Saturating count of rejected glitches on this channel.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        gcnt_q <= '0;
      end else begin
        gcnt_q <= gcnt_d;
      end
    end
`endif
  end

  // Single registered change strobe shared by all channels.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= |upd;
    end
  end

`ifdef SENSOR_FAULT_EN
  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fault_q <= 1'b0;
    end else if (|hit) begin
      fault_q <= 1'b1;
    end
  end

  assign bus.fault = fault_q;
`else
  assign bus.fault = 1'b0;
`endif

  assign bus.head    = lvl[0];
  assign bus.left    = lvl[1];
  assign bus.under   = lvl[2];
  assign bus.barrier = lvl[3];
  assign bus.changed = changed_q;

endmodule

// File: tb/tb_sensor_debounce.sv
// Testbench for sensor_debounce: directed table, hand-written corner
// sequences and a randomized run against a run-length reference model.
module tb_sensor_debounce;

  localparam int D  = 4;
  localparam int GL = 8;
`ifdef SENSOR_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;

  sensor_debounce_if bus ();

  sensor_debounce #(
    .DEBOUNCE_CYCLES (D),
    .GLITCH_LIMIT    (GL)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] lvl();
    return {bus.barrier, bus.under, bus.left, bus.head};
  endfunction

  function automatic logic [3:0] raw_vec();
    return {bus.raw_barrier, bus.raw_under, bus.raw_left, bus.raw_head};
  endfunction

  task automatic set_raw(input logic [3:0] v);
    bus.raw_head    = v[0];
    bus.raw_left    = v[1];
    bus.raw_under   = v[2];
    bus.raw_barrier = v[3];
  endtask

  // Leaves the bench at a falling edge with reset just released.
  task automatic do_reset();
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Reference model: samples pass through a two-deep delay line; a channel's
  // level flips once D consecutive delayed samples disagree with it, and a
  // disagreeing run that ends early is a rejected glitch.
  bit [3:0] m_s1, m_s2, m_out;
  int       m_run [4];
  int       m_gl  [4];
  bit       m_changed, m_fault, m_any;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_s1 = '0; m_s2 = '0; m_out = '0;
      m_changed = 1'b0; m_fault = 1'b0;
      for (int c = 0; c < 4; c++) begin
        m_run[c] = 0;
        m_gl[c]  = 0;
      end
    end else begin
      m_any = 1'b0;
      for (int c = 0; c < 4; c++) begin
        if (m_s2[c] != m_out[c]) begin
          m_run[c] = m_run[c] + 1;
          if (m_run[c] == D) begin
            m_out[c] = m_s2[c];
            m_run[c] = 0;
            m_any    = 1'b1;
          end
        end else begin
          if (m_run[c] != 0 && m_gl[c] < 15) begin
            m_gl[c] = m_gl[c] + 1;
            if (m_gl[c] == GL) m_fault = 1'b1;
          end
          m_run[c] = 0;
        end
      end
      m_changed = m_any;
      m_s2 = m_s1;
      m_s1 = raw_vec();
    end
  end

  typedef struct {
    logic [3:0] raw;
    int         cycles;
    logic [3:0] exp_lvl;
    int         exp_pulses;
  } vec_t;

  vec_t tbl [10];
  int   pulses;

  initial begin
    set_raw(4'b0000);

    // Reset state, including raw activity while reset is held.
    #3;
    check("reset_lvl", lvl(), 4'b0000);
    check("reset_changed", bus.changed, 1'b0);
    check("reset_fault", bus.fault, 1'b0);
    set_raw(4'b1000);
    repeat (3) @(negedge clock);
    check("reset_hold_lvl", {bus.changed, lvl()}, 5'b0);

    // Release with raw_barrier held: rises with changed at edge D+2 only.
    reset = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      check($sformatf("release_barrier_e%0d", k), lvl(), (k >= D + 2) ? 4'b1000 : 4'b0000);
      check($sformatf("release_changed_e%0d", k), bus.changed, (k == D + 2) ? 1'b1 : 1'b0);
    end

    // Table of held vectors starting from a cleared state.
    tbl[0] = '{4'b0001, 8,  4'b0001, 1};
    tbl[1] = '{4'b0110, 8,  4'b0110, 1};
    tbl[2] = '{4'b1110, 3,  4'b0110, 0};
    tbl[3] = '{4'b0110, 8,  4'b0110, 0};
    tbl[4] = '{4'b1001, 10, 4'b1001, 1};
    tbl[5] = '{4'b0000, 6,  4'b0000, 1};
    tbl[6] = '{4'b1111, 5,  4'b0000, 0};
    tbl[7] = '{4'b1111, 1,  4'b1111, 1};
    tbl[8] = '{4'b0000, 2,  4'b1111, 0};
    tbl[9] = '{4'b1111, 6,  4'b1111, 0};
    set_raw(4'b0000);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_raw(tbl[i].raw);
      pulses = 0;
      repeat (tbl[i].cycles) begin
        @(negedge clock);
        if (bus.changed === 1'b1) pulses++;
      end
      check($sformatf("tbl%0d_lvl", i), lvl(), tbl[i].exp_lvl);
      check($sformatf("tbl%0d_pulses", i), pulses, tbl[i].exp_pulses);
    end

    // Three-cycle head pulse never reaches the output.
    set_raw(4'b0000);
    do_reset();
    set_raw(4'b0001);
    repeat (3) @(negedge clock);
    set_raw(4'b0000);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      check("short_pulse_head", {bus.changed, bus.head}, 2'b00);
    end

    // Reset mid-CHECK aborts the pending under transition.
    set_raw(4'b0100);
    do_reset();
    repeat (3) @(negedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("abort_under_async", {bus.changed, bus.under}, 2'b00);
    set_raw(4'b0000);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      check("abort_no_change", {bus.changed, lvl()}, 5'b0);
    end

    // under held through reset, rises D+2 edges after release, then
    // clears asynchronously when reset is asserted between edges.
    reset = 1'b0;
    set_raw(4'b0100);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      check($sformatf("under_release_e%0d", k), bus.under, (k >= D + 2) ? 1'b1 : 1'b0);
    end
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("under_async_clear", lvl(), 4'b0000);
    @(negedge clock);
    set_raw(4'b0000);
    reset = 1'b1;

    // Eight three-cycle glitches on raw_left.
    do_reset();
    for (int g = 1; g <= 8; g++) begin
      set_raw(4'b0010);
      repeat (3) @(negedge clock);
      set_raw(4'b0000);
      repeat (5) @(negedge clock);
      check($sformatf("glitch%0d_fault", g), bus.fault, (FAULT_EN && g >= GL) ? 1'b1 : 1'b0);
      check($sformatf("glitch%0d_left", g), bus.left, 1'b0);
    end
    repeat (20) @(negedge clock);
    check("fault_sticky", bus.fault, FAULT_EN);
    reset = 1'b0;
    #1;
    check("fault_reset_clear", bus.fault, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    // Randomized activity against the reference model.
    for (int n = 0; n < 2400; n++) begin
      @(negedge clock);
      check("rand_model", {bus.fault, bus.changed, lvl()},
            {FAULT_EN & m_fault, m_changed, m_out});
      if (reset == 1'b0) begin
        reset = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
      end
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, ((n / 300) % 2 == 0) ? 9 : 2) == 0) begin
          case (c)
            0: bus.raw_head    = ~bus.raw_head;
            1: bus.raw_left    = ~bus.raw_left;
            2: bus.raw_under   = ~bus.raw_under;
            default: bus.raw_barrier = ~bus.raw_barrier;
          endcase
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
